// File: rtl/axis_uart_duplex_if.sv
// Stream-side bundle of the AXIS/UART bridge: TX slave channel in, RX master channel out.
// The bridge uses the slave modport; the traffic source/sink uses the master modport.
interface axis_uart_duplex_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] s_axis_data;
  logic                 s_axis_valid;
  logic                 s_axis_ready;
  logic                 s_axis_last;
  logic [DATA_BITS-1:0] m_axis_data;
  logic                 m_axis_valid;
  logic                 m_axis_ready;

  modport slave (
    input  s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
    output s_axis_ready, m_axis_data, m_axis_valid
  );

  modport master (
    output s_axis_data, s_axis_valid, s_axis_last, m_axis_ready,
    input  s_axis_ready, m_axis_data, m_axis_valid
  );
endinterface

// File: rtl/axis_uart_duplex.sv
// Full-duplex AXIS <-> UART bridge with TX/RX FIFOs, optional parity and line-error pulses.
// Define UART_LOOPBACK_EN to feed the RX deserializer from the internal TX line.
module axis_uart_duplex #(
  parameter int DATA_BITS = 8,
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD      = 115200,
  parameter int TX_DEPTH  = 4,
  parameter int RX_DEPTH  = 4,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  axis_uart_duplex_if.slave axis,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic              tx_busy,
  output logic              err_parity,
  output logic              err_frame,
  output logic              err_overrun
);
  localparam int DIV        = CLK_FREQ / BAUD;
  localparam int TAW        = $clog2(TX_DEPTH);
  localparam int RAW        = $clog2(RX_DEPTH);
  localparam int PBITS      = (PARITY != 0) ? 1 : 0;
  localparam int FRAME_CLKS = (1 + DATA_BITS + PBITS + STOP_BITS) * DIV;
  localparam int CW         = $clog2(FRAME_CLKS + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(DIV / 2);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * DIV - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(FRAME_CLKS - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 2) ? ~(^d) : ^d;
  endfunction

  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP, T_GAP} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_state_t;

  // TX FIFO: entries hold {last, data}
  logic [DATA_BITS:0]   tx_mem [TX_DEPTH];
  logic [TAW:0]         tx_wr_q, tx_rd_q;
  logic                 tx_empty, tx_full, tx_push, tx_pop, tx_shift, tx_next;
  logic [DATA_BITS:0]   tx_head;
  tx_state_t            tx_st_q, tx_st_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic                 tx_line_q, tx_line_d;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic                 tx_par_q, tx_last_q;

  assign tx_empty          = (tx_wr_q == tx_rd_q);
  assign tx_full           = (tx_wr_q[TAW] != tx_rd_q[TAW]) && (tx_wr_q[TAW-1:0] == tx_rd_q[TAW-1:0]);
  assign axis.s_axis_ready = ~tx_full;
  assign tx_push           = axis.s_axis_valid & ~tx_full;
  assign tx_head           = tx_mem[tx_rd_q[TAW-1:0]];
  assign uart_tx           = tx_line_q;
  assign tx_busy           = (tx_st_q != T_IDLE) | ~tx_empty;

  always_comb begin
    tx_st_d   = tx_st_q;
    tx_cnt_d  = tx_cnt_q + 1'b1;
    tx_bit_d  = tx_bit_q;
    tx_line_d = tx_line_q;
    tx_pop    = 1'b0;
    tx_shift  = 1'b0;
    tx_next   = 1'b0;
    unique case (tx_st_q)
      T_IDLE:  tx_next = 1'b1;
      T_START: if (tx_cnt_q == BIT_END) begin
        tx_st_d   = T_DATA;
        tx_cnt_d  = '0;
        tx_bit_d  = '0;
        tx_line_d = tx_sh_q[0];
      end
      T_DATA: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        if (tx_bit_q == LAST_BIT) begin
          tx_st_d   = (PARITY != 0) ? T_PAR : T_STOP;
          tx_line_d = (PARITY != 0) ? tx_par_q : 1'b1;
        end else begin
          tx_bit_d  = tx_bit_q + 4'd1;
          tx_shift  = 1'b1;
          tx_line_d = tx_sh_q[1];
        end
      end
      T_PAR: if (tx_cnt_q == BIT_END) begin
        tx_st_d   = T_STOP;
        tx_cnt_d  = '0;
        tx_line_d = 1'b1;
      end
      T_STOP: if (tx_cnt_q == STOP_END) begin
        if (tx_last_q) begin
          tx_st_d  = T_GAP;
          tx_cnt_d = '0;
        end else begin
          tx_next = 1'b1;
        end
      end
      T_GAP:   if (tx_cnt_q == GAP_END) tx_next = 1'b1;
      default: tx_st_d = T_IDLE;
    endcase
    // Frame boundary: chain straight into the next start bit when a character is waiting
    if (tx_next) begin
      tx_cnt_d  = '0;
      tx_line_d = tx_empty;
      tx_pop    = ~tx_empty;
      tx_st_d   = tx_empty ? T_IDLE : T_START;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st_q   <= T_IDLE;
      tx_cnt_q  <= '0;
      tx_bit_q  <= '0;
      tx_line_q <= 1'b1;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bit_q  <= tx_bit_d;
      tx_line_q <= tx_line_d;
      if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q[TAW-1:0]] <= {axis.s_axis_last, axis.s_axis_data};
    if (tx_pop) begin
      tx_sh_q   <= tx_head[DATA_BITS-1:0];
      tx_par_q  <= par_bit(tx_head[DATA_BITS-1:0]);
      tx_last_q <= tx_head[DATA_BITS];
    end else if (tx_shift) begin
      tx_sh_q <= tx_sh_q >> 1;
    end
  end

  logic rx_in;
`ifdef UART_LOOPBACK_EN
  assign rx_in = tx_line_q;
  wire unused_uart_rx = uart_rx;
`else
  assign rx_in = uart_rx;
`endif

  rx_state_t            rx_st_q, rx_st_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic                 rx_s1_q, rx_s2_q, rx_s3_q;
  logic                 rx_perr_q, rx_perr_d, rx_push_q, rx_push_d, rx_shift;
  logic                 err_par_q, err_par_d, err_frm_q, err_frm_d, err_ovr_q, err_ovr_d;
  logic [DATA_BITS-1:0] rx_sh_q;

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_cnt_d  = rx_cnt_q + 1'b1;
    rx_bit_d  = rx_bit_q;
    rx_perr_d = rx_perr_q;
    rx_shift  = 1'b0;
    rx_push_d = 1'b0;
    err_par_d = 1'b0;
    err_frm_d = 1'b0;
    unique case (rx_st_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (rx_s3_q & ~rx_s2_q) begin
          rx_st_d   = R_START;
          rx_perr_d = 1'b0;
        end
      end
      R_START: if (rx_cnt_q == HALF_END) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d  = rx_s2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d = '0;
        rx_shift = 1'b1;
        if (rx_bit_q == LAST_BIT) rx_st_d = (PARITY != 0) ? R_PAR : R_STOP;
        else                      rx_bit_d = rx_bit_q + 4'd1;
      end
      R_PAR: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d  = '0;
        rx_perr_d = rx_s2_q ^ par_bit(rx_sh_q);
        rx_st_d   = R_STOP;
      end
      // Only the first stop bit is checked; re-arm right after it
      R_STOP: if (rx_cnt_q == BIT_END) begin
        rx_st_d   = R_IDLE;
        err_frm_d = ~rx_s2_q;
        err_par_d = rx_perr_q;
        rx_push_d = rx_s2_q & ~rx_perr_q;
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  // RX FIFO, first-word fall-through
  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [RAW:0]         rx_wr_q, rx_rd_q;
  logic                 rx_empty, rx_full, rx_pop, rx_acc;

  assign rx_empty          = (rx_wr_q == rx_rd_q);
  assign rx_full           = (rx_wr_q[RAW] != rx_rd_q[RAW]) && (rx_wr_q[RAW-1:0] == rx_rd_q[RAW-1:0]);
  assign axis.m_axis_valid = ~rx_empty;
  assign axis.m_axis_data  = rx_empty ? '0 : rx_mem[rx_rd_q[RAW-1:0]];
  assign rx_pop            = ~rx_empty & axis.m_axis_ready;
  assign rx_acc            = rx_push_q & (~rx_full | rx_pop);
  assign err_ovr_d         = rx_push_q & rx_full & ~rx_pop;
  assign err_parity        = err_par_q;
  assign err_frame         = err_frm_q;
  assign err_overrun       = err_ovr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_st_q   <= R_IDLE;
      rx_cnt_q  <= '0;
      rx_bit_q  <= '0;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_s3_q   <= 1'b1;
      rx_perr_q <= 1'b0;
      rx_push_q <= 1'b0;
      err_par_q <= 1'b0;
      err_frm_q <= 1'b0;
      err_ovr_q <= 1'b0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
    end else begin
      rx_s1_q   <= rx_in;
      rx_s2_q   <= rx_s1_q;
      rx_s3_q   <= rx_s2_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_bit_q  <= rx_bit_d;
      rx_perr_q <= rx_perr_d;
      rx_push_q <= rx_push_d;
      err_par_q <= err_par_d;
      err_frm_q <= err_frm_d;
      err_ovr_q <= err_ovr_d;
      if (rx_acc) rx_wr_q <= rx_wr_q + 1'b1;
      if (rx_pop) rx_rd_q <= rx_rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_shift) rx_sh_q <= {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
    if (rx_acc)   rx_mem[rx_wr_q[RAW-1:0]] <= rx_sh_q;
  end
endmodule

// File: tb/tb_axis_uart_duplex.sv
// Directed bench for axis_uart_duplex: instance A (no parity) loops its TX line back in the
// bench or takes injected frames; instance B (even parity) only takes injected frames.
module tb_axis_uart_duplex;
  localparam int DIV = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ext_sel, rx_drv;
  logic uart_tx_a, uart_rx_a, tx_busy_a, ep_a, ef_a, eo_a;
  logic uart_tx_b, uart_rx_b, tx_busy_b, ep_b, ef_b, eo_b;

  axis_uart_duplex_if #(.DATA_BITS(8)) axis_a ();
  axis_uart_duplex_if #(.DATA_BITS(8)) axis_b ();

  assign uart_rx_a = ext_sel ? rx_drv : uart_tx_a;
  assign uart_rx_b = rx_drv;

  axis_uart_duplex #(.DATA_BITS(8), .CLK_FREQ(1000000), .BAUD(100000), .TX_DEPTH(4),
                     .RX_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .rst(rst_n), .axis(axis_a), .uart_rx(uart_rx_a), .uart_tx(uart_tx_a),
    .tx_busy(tx_busy_a), .err_parity(ep_a), .err_frame(ef_a), .err_overrun(eo_a));

  axis_uart_duplex #(.DATA_BITS(8), .CLK_FREQ(1000000), .BAUD(100000), .TX_DEPTH(4),
                     .RX_DEPTH(4), .PARITY(1), .STOP_BITS(1)) u_dut_b (
    .clk(clk), .rst(rst_n), .axis(axis_b), .uart_rx(uart_rx_b), .uart_tx(uart_tx_b),
    .tx_busy(tx_busy_b), .err_parity(ep_b), .err_frame(ef_b), .err_overrun(eo_b));

  int checks = 0, fails = 0;
  int cyc = 0, np_a = 0, nf_a = 0, no_a = 0, np_b = 0, nf_b = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ep_a) np_a <= np_a + 1;
    if (ef_a) nf_a <= nf_a + 1;
    if (eo_a) no_a <= no_a + 1;
    if (ep_b) np_b <= np_b + 1;
    if (ef_b) nf_b <= nf_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] d, input logic last);
    int t = 0;
    axis_a.s_axis_data  = d;
    axis_a.s_axis_last  = last;
    axis_a.s_axis_valid = 1'b1;
    while (!axis_a.s_axis_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("push_ready", {31'd0, axis_a.s_axis_ready}, 1);
    @(negedge clk);
    axis_a.s_axis_valid = 1'b0;
    axis_a.s_axis_last  = 1'b0;
  endtask

  task automatic wait_tx_low(input int bound);
    int t = 0;
    while (uart_tx_a !== 1'b0 && t < bound) begin
      @(negedge clk);
      t++;
    end
    check("tx_start_seen", {31'd0, uart_tx_a}, 0);
  endtask

  task automatic wait_tx_idle(input int bound);
    int t = 0;
    while (tx_busy_a !== 1'b0 && t < bound) begin
      @(negedge clk);
      t++;
    end
    check("tx_idle", {31'd0, tx_busy_a}, 0);
    repeat (20) @(negedge clk);
  endtask

  task automatic pop_a(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, {31'd0, axis_a.m_axis_valid}, 1);
    check(tag, {24'd0, axis_a.m_axis_data}, {24'd0, exp});
    axis_a.m_axis_ready = 1'b1;
    @(negedge clk);
    axis_a.m_axis_ready = 1'b0;
  endtask

  task automatic inject(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv = bits[i];
      repeat (DIV) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t0, lat, n, p0, f0, o0;
    logic [9:0] exp1;
    logic [7:0] w2 [6];

    rst_n = 1'b0; ext_sel = 1'b0; rx_drv = 1'b1;
    axis_a.s_axis_data = '0; axis_a.s_axis_valid = 1'b0; axis_a.s_axis_last = 1'b0;
    axis_a.m_axis_ready = 1'b0;
    axis_b.s_axis_data = '0; axis_b.s_axis_valid = 1'b0; axis_b.s_axis_last = 1'b0;
    axis_b.m_axis_ready = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_uart_tx", {31'd0, uart_tx_a}, 1);
    check("rst_s_ready", {31'd0, axis_a.s_axis_ready}, 1);
    check("rst_m_valid", {31'd0, axis_a.m_axis_valid}, 0);
    check("rst_m_data", {24'd0, axis_a.m_axis_data}, 0);
    check("rst_tx_busy", {31'd0, tx_busy_a}, 0);
    check("rst_errs", {29'd0, ep_a, ef_a, eo_a}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: single 0xA5 through the loopback
    axis_a.s_axis_data = 8'hA5; axis_a.s_axis_valid = 1'b1;
    @(negedge clk);
    axis_a.s_axis_valid = 1'b0;
    check("t1_line_at_handshake", {31'd0, uart_tx_a}, 1);
    check("t1_busy", {31'd0, tx_busy_a}, 1);
    @(negedge clk);
    check("t1_start_one_cycle", {31'd0, uart_tx_a}, 0);
    t0 = cyc;
    exp1 = 10'b1101001010;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check("t1_line_bit", {31'd0, uart_tx_a}, {31'd0, exp1[k]});
      if (k < 9) repeat (DIV) @(negedge clk);
    end
    t = 0;
    while (!axis_a.m_axis_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    lat = cyc - t0;
    check("t1_rx_latency_in_100_101", {31'd0, (lat >= 100 && lat <= 101)}, 1);
    pop_a("t1_rx_data", 8'hA5);
    check("t1_rx_empty", {31'd0, axis_a.m_axis_valid}, 0);

    // Test 2: six words, RX consumer stalled
    w2[0] = 8'h3C; w2[1] = 8'hC3; w2[2] = 8'h5A; w2[3] = 8'h81; w2[4] = 8'hFF; w2[5] = 8'h00;
    o0 = no_a; p0 = np_a; f0 = nf_a;
    push_a(w2[0], 1'b0);
    @(negedge clk);
    for (int i = 1; i < 5; i++) push_a(w2[i], 1'b0);
    check("t2_ready_low_when_full", {31'd0, axis_a.s_axis_ready}, 0);
    push_a(w2[5], 1'b0);
    wait_tx_idle(1000);
    check("t2_overrun_pulses", no_a - o0, 2);
    check("t2_no_line_errors", (np_a - p0) + (nf_a - f0), 0);
    for (int i = 0; i < 4; i++) pop_a("t2_rx_order", w2[i]);
    check("t2_rx_drained", {31'd0, axis_a.m_axis_valid}, 0);

    // Test 3: even parity on instance B, injected frames
    p0 = np_b; f0 = nf_b;
    inject({5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
    repeat (10) @(negedge clk);
    check("t3_perr_pulse", np_b - p0, 1);
    check("t3_no_frame_err", nf_b - f0, 0);
    check("t3_bad_word_dropped", {31'd0, axis_b.m_axis_valid}, 0);
    inject({5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
    repeat (10) @(negedge clk);
    check("t3_good_valid", {31'd0, axis_b.m_axis_valid}, 1);
    check("t3_good_data", {24'd0, axis_b.m_axis_data}, 32'h03);
    check("t3_perr_unchanged", np_b - p0, 1);
    axis_b.m_axis_ready = 1'b1;
    @(negedge clk);
    axis_b.m_axis_ready = 1'b0;

    // Test 4: framing error on instance A, then a clean frame
    ext_sel = 1'b1;
    p0 = np_a; f0 = nf_a;
    inject({6'b0, 1'b0, 8'h55, 1'b0}, 10);
    repeat (30) @(negedge clk);
    check("t4_ferr_pulse", nf_a - f0, 1);
    check("t4_no_perr", np_a - p0, 0);
    check("t4_bad_word_dropped", {31'd0, axis_a.m_axis_valid}, 0);
    inject({6'b0, 1'b1, 8'h12, 1'b0}, 10);
    repeat (10) @(negedge clk);
    pop_a("t4_good_data", 8'h12);
    check("t4_ferr_unchanged", nf_a - f0, 1);
    ext_sel = 1'b0;
    repeat (5) @(negedge clk);

    // Test 5: inter-packet gap after last, none otherwise
    for (int pass = 0; pass < 2; pass++) begin
      push_a(8'h01, (pass == 0));
      push_a(8'h02, 1'b0);
      wait_tx_low(20);
      repeat (100) @(negedge clk);
      n = 0;
      while (uart_tx_a === 1'b1 && n < 300) begin
        n++;
        @(negedge clk);
      end
      check(pass == 0 ? "t5_gap_with_last" : "t5_gap_without_last", n, pass == 0 ? 100 : 0);
      wait_tx_idle(400);
      pop_a("t5_rx_first", 8'h01);
      pop_a("t5_rx_second", 8'h02);
    end

    // Test 6: reset in the middle of data bit 3
    p0 = np_a; f0 = nf_a;
    push_a(8'h96, 1'b0);
    wait_tx_low(20);
    repeat (45) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_tx_high_async", {31'd0, uart_tx_a}, 1);
    check("t6_busy_cleared", {31'd0, tx_busy_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    check("t6_nothing_received", {31'd0, axis_a.m_axis_valid}, 0);
    check("t6_no_errors", (np_a - p0) + (nf_a - f0), 0);
    push_a(8'h69, 1'b0);
    wait_tx_idle(300);
    pop_a("t6_after_reset_data", 8'h69);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
